// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the instruction-memory stream loader
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    localparam logic [31:0] TEXT_BASE      = 32'h0000_3000;
    localparam logic [31:0] DATA_BASE      = 32'h0000_0000;
    localparam int          WORD_W         = 32;
    localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - shifts bytes big-endian into a word and flags the fourth byte
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 2'd0;
            word  <= '0;
        end else if (byte_en) begin
            // first byte ends up in the top lane after four shifts
            word  <= {word[WORD_W-9:0], byte_data};
            count <= count + 2'd1;
        end
    end

    assign word_valid = byte_en && (count == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_stream_loader.sv
// rtl/imem_stream_loader.sv - loads a byte stream into instruction memory while holding the CPU in reset
module imem_stream_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len_words,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum
);

    localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(DEPTH);

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   n_words;
    logic [LEN_W-1:0]   word_idx;
    logic [LEN_W-1:0]   idx_inc;
    logic [ADDR_W-1:0]  addr_q;
    logic               accept_start;
    logic               start_bad;
    logic               start_load;
    logic               byte_fire;
    logic [WORD_W-1:0]  word;
    logic               word_valid;

    assign accept_start = start && (state == IDLE || state == DONE);
    assign start_bad    = {1'b0, len_words} > DEPTH_L;
    assign start_load   = accept_start && !start_bad;
    assign byte_ready   = (state == LOAD);
    assign byte_fire    = byte_valid && byte_ready;
    assign idx_inc      = word_idx + LEN_W'(1);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_load),
        .byte_en    (byte_fire),
        .byte_data  (byte_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                // a rejected start from DONE falls back to IDLE so the core is held again
                if (start) begin
                    if (start_bad) begin
                        state_nxt = IDLE;
                    end else if (len_words == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                if (word_valid) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = (idx_inc == n_words) ? DONE : LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_words  <= '0;
            word_idx <= '0;
            addr_q   <= '0;
            checksum <= '0;
            error    <= 1'b0;
        end else begin
            if (accept_start) begin
                if (start_bad) begin
                    error <= 1'b1;
                end else begin
                    error    <= 1'b0;
                    n_words  <= len_words;
                    word_idx <= '0;
                    addr_q   <= '0;
                    checksum <= '0;
                end
            end
            if (state == LOAD && word_valid) begin
                addr_q <= word_idx[ADDR_W-1:0];
            end
            if (state == WRITE) begin
                checksum <= checksum + word;
                word_idx <= idx_inc;
            end
        end
    end

    assign im_we    = (state == WRITE);
    assign im_addr  = addr_q;
    assign im_wdata = word;
    assign cpu_rst  = (state != DONE);
    assign busy     = (state == LOAD) || (state == WRITE);
    assign done     = (state == DONE);

endmodule
